// File: rtl/arc4_encrypt_pkg.sv
// Shared types and constants for the ARC4 encryptor and its key scheduler.
package arc4_pkg;

    localparam int unsigned S_DEPTH   = 256;
    localparam int unsigned KEY_BYTES = 3;
    localparam logic [7:0]  PRINT_LO  = 8'h20;
    localparam logic [7:0]  PRINT_HI  = 8'h7E;

    // Top-level flow: scheduler hand-off, length byte, then per-byte PRGA steps
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SCHED,
        ST_LEN_RD,
        ST_LEN_WR,
        ST_P_RD_I,
        ST_P_CAP_I,
        ST_P_RD_J,
        ST_P_CAP_J,
        ST_P_WR_I,
        ST_P_WR_J,
        ST_P_RD_PAD,
        ST_P_WR_CT,
        ST_DONE
    } enc_state_t;

    // S-array init followed by the key-schedule swap loop
    typedef enum logic [2:0] {
        SC_IDLE,
        SC_INIT,
        SC_RD_I,
        SC_CAP_I,
        SC_RD_J,
        SC_CAP_J,
        SC_WR_I,
        SC_WR_J
    } sched_state_t;

    // Key bytes are taken MSB-first: byte 0 is the top byte of the key
    function automatic logic [7:0] keybyte(input logic [KEY_BYTES*8-1:0] key,
                                           input logic [1:0]             idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = key[23:16];
            2'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake plus pt/ct/S memory bus of the ARC4 encryptor.
// master: the encryptor; slave: the memories and requester around it.
interface arc4_encrypt_if #(
    parameter int KEY_W  = 24,
    parameter int MEM_AW = 8
);
    logic              en;
    logic              rdy;
    logic [KEY_W-1:0]  key;
    logic [MEM_AW-1:0] pt_addr;
    logic [7:0]        pt_rddata;
    logic [MEM_AW-1:0] ct_addr;
    logic [7:0]        ct_wrdata;
    logic              ct_wren;
    logic [MEM_AW-1:0] s_addr;
    logic [7:0]        s_rddata;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic              pt_err;

    modport master (
        input  en, key, pt_rddata, s_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren,
               s_addr, s_wrdata, s_wren, pt_err
    );

    modport slave (
        output en, key, pt_rddata, s_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren,
               s_addr, s_wrdata, s_wren, pt_err
    );
endinterface

// File: rtl/arc4_encrypt_sched.sv
// ARC4 S-array initialisation and key schedule (KSA) over the external S RAM.
// Starts on en while rdy=1; rdy returns high once the KSA loop finishes.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int KEY_W  = 24,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [MEM_AW-1:0] s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren
);

    sched_state_t     state, nxt;
    logic [7:0]       i, j, si, sj;
    logic [1:0]       kidx;
    logic [KEY_W-1:0] key_q;
    logic             last_i;

    assign last_i = (i == 8'(S_DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= SC_IDLE;
        else        state <= nxt;
    end

    // Next-state: 256 init writes, then six steps per KSA index
    always_comb begin
        nxt = state;
        case (state)
            SC_IDLE:  if (en) nxt = SC_INIT;
            SC_INIT:  if (last_i) nxt = SC_RD_I;
            SC_RD_I:  nxt = SC_CAP_I;
            SC_CAP_I: nxt = SC_RD_J;
            SC_RD_J:  nxt = SC_CAP_J;
            SC_CAP_J: nxt = SC_WR_I;
            SC_WR_I:  nxt = SC_WR_J;
            SC_WR_J:  nxt = last_i ? SC_IDLE : SC_RD_I;
            default:  nxt = SC_IDLE;
        endcase
    end

    // Index, captured S values and key-byte selector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            kidx  <= '0;
            key_q <= '0;
        end else begin
            case (state)
                SC_IDLE: if (en) begin
                    key_q <= key;
                    i     <= '0;
                    j     <= '0;
                    kidx  <= '0;
                end
                SC_INIT:  i <= i + 8'd1;
                SC_CAP_I: begin
                    si <= s_rddata;
                    j  <= j + s_rddata + keybyte(key_q, kidx);
                end
                SC_CAP_J: sj <= s_rddata;
                SC_WR_J: begin
                    i    <= i + 8'd1;
                    kidx <= (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // S-port drive per state
    always_comb begin
        rdy      = (state == SC_IDLE);
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state)
            SC_INIT: begin
                s_addr   = MEM_AW'(i);
                s_wrdata = i;
                s_wren   = 1'b1;
            end
            SC_RD_I: s_addr = MEM_AW'(i);
            SC_RD_J: s_addr = MEM_AW'(j);
            SC_WR_I: begin
                s_addr   = MEM_AW'(i);
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            SC_WR_J: begin
                s_addr   = MEM_AW'(j);
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed pt memory -> length-prefixed ct memory.
// INIT+KSA run in arc4_sched; this level sequences length handling and PRGA.
// Optional macro ARC4_ENC_PRINTABLE_CHECK_EN builds the sticky pt_err check.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_W  = 24,
    parameter int MEM_AW = 8
) (
    input  logic clk,
    input  logic rst_n,
    arc4_encrypt_if.master bus
);

    enc_state_t        state, nxt;
    logic [7:0]        i, j, k, len, si, sj;
    logic              sched_en, sched_rdy, sched_wren;
    logic [MEM_AW-1:0] sched_addr;
    logic [7:0]        sched_wrdata;

    // The scheduler is idle whenever this level is idle, so it starts in lockstep
    assign sched_en = (state == ST_IDLE) && bus.en;

    arc4_sched #(.KEY_W(KEY_W), .MEM_AW(MEM_AW)) u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (sched_en),
        .rdy      (sched_rdy),
        .key      (bus.key),
        .s_addr   (sched_addr),
        .s_rddata (bus.s_rddata),
        .s_wrdata (sched_wrdata),
        .s_wren   (sched_wren)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next-state: wait for scheduler, handle length, then eight steps per byte
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:     if (bus.en) nxt = ST_SCHED;
            ST_SCHED:    if (sched_rdy) nxt = ST_LEN_RD;
            ST_LEN_RD:   nxt = ST_LEN_WR;
            ST_LEN_WR:   nxt = (bus.pt_rddata == 8'd0) ? ST_DONE : ST_P_RD_I;
            ST_P_RD_I:   nxt = ST_P_CAP_I;
            ST_P_CAP_I:  nxt = ST_P_RD_J;
            ST_P_RD_J:   nxt = ST_P_CAP_J;
            ST_P_CAP_J:  nxt = ST_P_WR_I;
            ST_P_WR_I:   nxt = ST_P_WR_J;
            ST_P_WR_J:   nxt = ST_P_RD_PAD;
            ST_P_RD_PAD: nxt = ST_P_WR_CT;
            ST_P_WR_CT:  nxt = (k == len) ? ST_DONE : ST_P_RD_I;
            ST_DONE:     nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
    end

    // PRGA indices, length and captured S values; k holds at len so it never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            len <= '0;
            si  <= '0;
            sj  <= '0;
        end else begin
            case (state)
                ST_LEN_WR: begin
                    len <= bus.pt_rddata;
                    i   <= '0;
                    j   <= '0;
                    k   <= 8'd1;
                end
                ST_P_RD_I:  i <= i + 8'd1;
                ST_P_CAP_I: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                ST_P_CAP_J: sj <= bus.s_rddata;
                ST_P_WR_CT: if (k != len) k <= k + 8'd1;
                default: ;
            endcase
        end
    end

    // Memory port drive; pad and pt[k] are read together and XORed on arrival
    always_comb begin
        bus.rdy       = (state == ST_IDLE);
        bus.pt_addr   = '0;
        bus.ct_addr   = '0;
        bus.ct_wrdata = '0;
        bus.ct_wren   = 1'b0;
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_wren    = 1'b0;
        case (state)
            ST_SCHED: begin
                bus.s_addr   = sched_addr;
                bus.s_wrdata = sched_wrdata;
                bus.s_wren   = sched_wren;
            end
            ST_LEN_WR: begin
                bus.ct_wrdata = bus.pt_rddata;
                bus.ct_wren   = 1'b1;
            end
            ST_P_RD_I: bus.s_addr = MEM_AW'(8'(i + 8'd1));
            ST_P_RD_J: bus.s_addr = MEM_AW'(j);
            ST_P_WR_I: begin
                bus.s_addr   = MEM_AW'(i);
                bus.s_wrdata = sj;
                bus.s_wren   = 1'b1;
            end
            ST_P_WR_J: begin
                bus.s_addr   = MEM_AW'(j);
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
            end
            ST_P_RD_PAD: begin
                bus.s_addr  = MEM_AW'(8'(si + sj));
                bus.pt_addr = MEM_AW'(k);
            end
            ST_P_WR_CT: begin
                bus.ct_addr   = MEM_AW'(k);
                bus.ct_wrdata = bus.pt_rddata ^ bus.s_rddata;
                bus.ct_wren   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
    logic pt_err_q;

    // Sticky flag: cleared on a new run, set by any non-printable payload byte
    always_ff @(posedge clk) begin
        if (!rst_n)
            pt_err_q <= 1'b0;
        else if (state == ST_IDLE && bus.en)
            pt_err_q <= 1'b0;
        else if (state == ST_P_WR_CT &&
                 (bus.pt_rddata < PRINT_LO || bus.pt_rddata > PRINT_HI))
            pt_err_q <= 1'b1;
    end

    assign bus.pt_err = pt_err_q;
`else
    assign bus.pt_err = 1'b0;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed self-checking bench for arc4_encrypt with behavioural pt/ct/S memories.
module tb_arc4_encrypt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arc4_encrypt_if #(.KEY_W(24), .MEM_AW(8)) bus ();

    arc4_encrypt #(.KEY_W(24), .MEM_AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  s_mem  [256];
    logic [7:0]  orig   [256];
    int unsigned ct_addr_cnt [256];
    int unsigned ct_wr_cnt, done_cnt;
    int unsigned both_wren_cnt = 0;
    logic        prev_rdy;
    logic        clr;

    logic [7:0]  vec_pt [10];
    logic [7:0]  vec_ct [10];

    int compared   = 0;
    int mismatched = 0;

    // Synchronous RAM models plus write/completion monitors
    always @(posedge clk) begin
        bus.s_rddata  <= s_mem[bus.s_addr];
        if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        bus.pt_rddata <= pt_mem[bus.pt_addr];
        prev_rdy      <= bus.rdy;
        if (bus.ct_wren && bus.s_wren) both_wren_cnt <= both_wren_cnt + 1;
        if (clr) begin
            for (int a = 0; a < 256; a++) begin
                ct_mem[a]      <= '0;
                ct_addr_cnt[a] <= 0;
            end
            ct_wr_cnt <= 0;
            done_cnt  <= 0;
        end else begin
            if (bus.ct_wren) begin
                ct_mem[bus.ct_addr]      <= bus.ct_wrdata;
                ct_addr_cnt[bus.ct_addr] <= ct_addr_cnt[bus.ct_addr] + 1;
                ct_wr_cnt                <= ct_wr_cnt + 1;
            end
            if (bus.rdy && !prev_rdy) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic start(input logic [23:0] k);
        @(negedge clk);
        bus.key = k;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget, output int unsigned cycles);
        cycles = 0;
        while (bus.rdy !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_timeout"}, {31'd0, bus.rdy}, 32'd1);
    endtask

    task automatic load_vec();
        for (int n = 0; n < 10; n++) pt_mem[n] = vec_pt[n];
    endtask

    task automatic check_vec(input string tag);
        for (int n = 0; n < 10; n++)
            check($sformatf("%s_ct%0d", tag, n), {24'd0, ct_mem[n]}, {24'd0, vec_ct[n]});
        check({tag, "_wrcnt"}, ct_wr_cnt, 32'd10);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned bad;

        vec_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        vec_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.key = '0;
        clr     = 1'b0;
        for (int a = 0; a < 256; a++) pt_mem[a] = '0;

        // Reset state
        clear_mon();
        @(negedge clk);
        check("rst_rdy",       {31'd0, bus.rdy},     32'd1);
        check("rst_ct_wren",   {31'd0, bus.ct_wren}, 32'd0);
        check("rst_s_wren",    {31'd0, bus.s_wren},  32'd0);
        check("rst_pt_addr",   {24'd0, bus.pt_addr}, 32'd0);
        check("rst_ct_addr",   {24'd0, bus.ct_addr}, 32'd0);
        check("rst_s_addr",    {24'd0, bus.s_addr},  32'd0);
        check("rst_ct_wrdata", {24'd0, bus.ct_wrdata}, 32'd0);
        check("rst_s_wrdata",  {24'd0, bus.s_wrdata},  32'd0);
        check("rst_pt_err",    {31'd0, bus.pt_err},  32'd0);
        rst_n = 1'b1;

        // Key "Key", "Plaintext", with en pulses while busy
        load_vec();
        clear_mon();
        start(24'h4B6579);
        check("a_rdy_low", {31'd0, bus.rdy}, 32'd0);
        repeat (10) @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (1000) @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_done("a", 4000, cyc);
        repeat (5) @(negedge clk);
        check("a_rdy_stays", {31'd0, bus.rdy}, 32'd1);
        check_vec("a");
        check("a_done_cnt", done_cnt, 32'd1);
        check("a_pt_err", {31'd0, bus.pt_err}, 32'd0);

        // Zero-length message
        pt_mem[0] = 8'h00;
        clear_mon();
        start(24'hA5C3F0);
        wait_done("len0", 2308, cyc);
        check("len0_latency", {31'd0, (cyc + 1 <= 2308)}, 32'd1);
        check("len0_wrcnt", ct_wr_cnt, 32'd1);
        check("len0_ct0_written", ct_addr_cnt[0], 32'd1);

        // Maximum length, key 0, then round-trip decrypt
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) begin
            pt_mem[n] = 8'(n * 37 + 11);
            orig[n]   = pt_mem[n];
        end
        clear_mon();
        start(24'h000000);
        wait_done("len255", 2308 + 12 * 255, cyc);
        check("len255_wrcnt", ct_wr_cnt, 32'd256);
        bad = 0;
        for (int n = 0; n < 256; n++) if (ct_addr_cnt[n] != 1) bad++;
        check("len255_once_each", bad, 32'd0);
        check("len255_ct0", {24'd0, ct_mem[0]}, 32'd255);
        bad = 0;
        for (int n = 1; n < 256; n++) if (ct_mem[n] == orig[n]) bad++;
        check("len255_scrambled", {31'd0, (bad < 32)}, 32'd1);
        for (int n = 1; n < 256; n++) pt_mem[n] = ct_mem[n];
        clear_mon();
        start(24'h000000);
        wait_done("dec255", 2308 + 12 * 255, cyc);
        bad = 0;
        for (int n = 1; n < 256; n++) if (ct_mem[n] != orig[n]) bad++;
        check("dec255_roundtrip", bad, 32'd0);
        check("dec255_wrcnt", ct_wr_cnt, 32'd256);

        // Reset during KSA with en held high, then a clean run restarts
        load_vec();
        @(negedge clk);
        bus.key = 24'h4B6579;
        bus.en  = 1'b1;
        repeat (600) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstksa_rdy",     {31'd0, bus.rdy},     32'd1);
        check("rstksa_ct_wren", {31'd0, bus.ct_wren}, 32'd0);
        check("rstksa_s_wren",  {31'd0, bus.s_wren},  32'd0);
        clear_mon();
        rst_n = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_done("rstksa", 4000, cyc);
        check_vec("rerun");

        // Non-printable payload bytes
        pt_mem[0] = 8'h03;
        pt_mem[1] = 8'h41;
        pt_mem[2] = 8'h0A;
        pt_mem[3] = 8'h42;
        clear_mon();
        start(24'h4B6579);
        wait_done("err", 4000, cyc);
        check("err_ct0", {24'd0, ct_mem[0]}, 32'h03);
        check("err_ct1", {24'd0, ct_mem[1]}, 32'hAA);
        check("err_ct2", {24'd0, ct_mem[2]}, 32'h95);
        check("err_ct3", {24'd0, ct_mem[3]}, 32'h35);
        check("err_wrcnt", ct_wr_cnt, 32'd4);
`ifdef ARC4_ENC_PRINTABLE_CHECK_EN
        check("err_pt_err", {31'd0, bus.pt_err}, 32'd1);
`else
        check("err_pt_err", {31'd0, bus.pt_err}, 32'd0);
`endif

        check("one_strobe", both_wren_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 encryptor: reads a length-prefixed plaintext message from pt memory and writes the length-prefixed ciphertext into ct memory.
- It is the writer on the ct_mem interface that the key-search/decrypt path reads.
- Owns the full ARC4 flow: S-array init, key schedule (KSA), then keystream XOR (PRGA).
- The S array lives in an external 256x8 synchronous RAM (s_mem).

Parameters:
- KEY_W, 24, key width in bits; key bytes are taken MSB-first (key[23:16] is key byte 0).
- MEM_AW, 8, address width for the pt, ct and s memories (depth 256).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high in IDLE; ready to accept en
- key  in  KEY_W  encryption key; latched on accepted en
- pt_addr  out  MEM_AW  plaintext read address
- pt_rddata  in  8  plaintext read data; one-cycle latency
- ct_addr  out  MEM_AW  ciphertext write address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write strobe
- s_addr  out  MEM_AW  S-array address
- s_rddata  in  8  S-array read data; one-cycle latency
- s_wrdata  out  8  S-array write data
- s_wren  out  1  S-array write strobe
- pt_err  out  1  non-printable plaintext flag (see Optional Feature)

Behaviour:
- Reset (synchronous, active-low, on clk): state=IDLE, rdy=1, ct_wren=0, s_wren=0, all addresses 0, write data 0, pt_err=0, i=j=k=0.
- Reset mid-operation aborts immediately. No write strobe is asserted in the cycle after reset is applied. Memory contents are not restored.
- Handshake:
  - en is accepted when rdy=1 and en=1. rdy drops the next cycle and stays low until completion.
  - en is ignored while busy.
  - On completion rdy returns to 1 and stays there until the next accepted en.
- Memory timing: address driven in cycle N, data valid in cycle N+1. Every read needs an address state and a capture state. Writes take effect at the edge where wren=1.
- States:
  - IDLE -> INIT on accepted en.
  - INIT: write S[i]=i for i=0..255, one write per cycle (256 cycles). Then go to KSA.
  - KSA, for i=0..255:
    - read S[i];
    - j = j + S[i] + keybyte[i mod 3], mod 256;
    - read S[j];
    - write S[i]=old S[j];
    - write S[j]=old S[i].
    - After i=255 go to RDLEN.
  - RDLEN: read pt[0] into len; write ct[0]=len. If len=0 go to DONE; else reset i=j=0, k=1 and go to PRGA.
  - PRGA, per byte k=1..len:
    - i=i+1;
    - read S[i];
    - j=j+S[i];
    - read S[j];
    - swap S[i] and S[j] (two writes);
    - read S[(S[i]+S[j]) mod 256] as pad;
    - read pt[k];
    - write ct[k] = pt[k] XOR pad.
    - After k=len go to DONE.
  - DONE -> IDLE, asserting rdy.
- Arithmetic: i, j, k and the pad index are all 8-bit, wrap mod 256. len=255 is the maximum; k never wraps past 255.
- At most one write strobe (ct_wren or s_wren) is high in any cycle.
- Each ct address is written exactly once per run.
- Latency bound: completion within 256 + 256*8 + 4 + 12*len cycles of the accepted en.

Optional Feature:
- Macro ARC4_ENC_PRINTABLE_CHECK_EN.
- Defined:
  - pt_err clears on accepted en.
  - pt_err sets (sticky) if any pt[k], k=1..len, is outside 8'h20..8'h7E.
  - Encryption still completes normally.
- Undefined: pt_err is tied to 0 and no comparison logic is built.

Decomposition:
- Package arc4_pkg holds:
  - the state enum typedef;
  - constants S_DEPTH=256, KEY_BYTES=3, PRINT_LO=8'h20, PRINT_HI=8'h7E;
  - a function keybyte(key, idx).
- One sub-module, arc4_sched, performs INIT+KSA: it has its own en/rdy handshake and drives the S-array port.
- The top FSM muxes s_* between arc4_sched and the PRGA datapath.

Test Plan:
- Key 24'h4B6579 ("Key"), pt = {9,"Plaintext"} -> ct = {09,BB,F3,16,E8,D9,40,AF,0A,D3}; rdy returns to 1 after completion.
- len=0, any key -> exactly one ct write (ct[0]=00); rdy returns within 256+2048+4 cycles.
- len=255, key 24'h000000 -> 256 ct writes, k stops at 255 with no address wrap; decrypting the result gives back the original plaintext.
- Assert rst_n=0 during KSA, with en held high -> the cycle after reset shows rdy=1 and no wren. Then a new en run with key "Key" still produces the vector from the first scenario.
- Pulse en while busy -> ignored; exactly one completion and one ct image produced.
- With ARC4_ENC_PRINTABLE_CHECK_EN defined, pt = {3,41,0A,42} -> pt_err=1 and ct still written. Without the macro -> pt_err stays 0.
